// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int DEF_CLK_FREQ   = 50_000_000;
    localparam int DEF_BAUD       = 115_200;
    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } rx_state_t;

    // Tick index inside a bit at which the line is sampled.
    function automatic int mid_idx(input int os);
        return os / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Output bundle of the UART receiver towards the command FSM.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
) ();
    import uart_pkg::*;

    // valid_o is a push-only strobe: data_o is valid in the same cycle and
    // there is no ready, so the consumer must take the byte when it pulses.
    logic [DATA_BITS-1:0] data_o;
    logic                 valid_o;
    logic                 frame_err_o;
    logic                 busy_o;
    rx_state_t            state_o;

    modport master (
        output data_o, valid_o, frame_err_o, busy_o, state_o
    );

    modport slave (
        input data_o, valid_o, frame_err_o, busy_o, state_o
    );
endinterface

// File: rtl/uart_baud_tick.sv
// Sample-tick divider: one-clock tick every TICK_DIV clocks, held at 0 by i_clr.
module uart_baud_tick #(
    parameter int TICK_DIV = 27
) (
    input  logic clk_i,
    input  logic rst_n,
    input  logic i_clr,
    output logic o_tick
);
    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;
    logic          w_wrap;

    assign w_wrap = (r_cnt == LAST) && !i_clr;
    assign o_tick = w_wrap;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clr || w_wrap) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1 serial receiver with 16x oversampling, LSB first, idle-high line.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = DEF_CLK_FREQ,
    parameter int BAUD       = DEF_BAUD,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DATA_BITS  = 8,
    parameter int TICK_DIV   = CLK_FREQ / (BAUD * OVERSAMPLE)
) (
    input  logic      clk_i,
    input  logic      rst_n,
    input  logic      rx_i,
    uart_rx_if.master rx_bus
);
    localparam int SW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [SW-1:0] MID_S  = SW'(mid_idx(OVERSAMPLE));
    localparam logic [SW-1:0] LAST_S = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_B = BW'(DATA_BITS - 1);

    logic                 r_rx_meta, r_rx_s, r_rx_d;
    rx_state_t            r_state, w_next;
    logic [SW-1:0]        r_samp;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift, r_data;
    logic                 r_valid, r_ferr;

    logic w_fall, w_tick, w_mid, w_clr;
    logic w_shift, w_load, w_ferr, w_bit_clr;

    assign w_fall = r_rx_d & ~r_rx_s;
    assign w_clr  = (r_state == IDLE);
    assign w_mid  = w_tick && (r_samp == MID_S);

    // Held clear in IDLE, so tick phase starts on the cycle after the start edge.
    uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk_i  (clk_i),
        .rst_n  (rst_n),
        .i_clr  (w_clr),
        .o_tick (w_tick)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_d    <= 1'b1;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_rx_d    <= r_rx_s;
        end
    end

    always_comb begin
        w_next    = r_state;
        w_shift   = 1'b0;
        w_load    = 1'b0;
        w_ferr    = 1'b0;
        w_bit_clr = 1'b0;
        case (r_state)
            IDLE: if (w_fall) w_next = START;
            START: if (w_mid) begin
                if (r_rx_s) begin
                    w_next = IDLE;
                end else begin
                    w_next    = DATA;
                    w_bit_clr = 1'b1;
                end
            end
            DATA: if (w_mid) begin
                w_shift = 1'b1;
                if (r_bit == LAST_B) w_next = STOP;
            end
            // Leaving at the stop mid-point lets a back-to-back start edge be caught.
            STOP: if (w_mid) begin
                if (r_rx_s) begin
                    w_load = 1'b1;
                    w_next = IDLE;
                end else begin
                    w_ferr = 1'b1;
                    w_next = BREAK;
                end
            end
            BREAK: if (r_rx_s) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_samp  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_data  <= '0;
            r_valid <= 1'b0;
            r_ferr  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_valid <= w_load;
            r_ferr  <= w_ferr;
            if (r_state == IDLE) begin
                r_samp <= '0;
            end else if (w_tick) begin
                r_samp <= (r_samp == LAST_S) ? '0 : r_samp + 1'b1;
            end
            if (w_bit_clr) begin
                r_bit <= '0;
            end else if (w_shift) begin
                r_bit <= r_bit + 1'b1;
            end
            if (w_shift) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
            if (w_load)  r_data  <= r_shift;
        end
    end

    assign rx_bus.data_o      = r_data;
    assign rx_bus.valid_o     = r_valid;
    assign rx_bus.frame_err_o = r_ferr;
    assign rx_bus.busy_o      = (r_state != IDLE);
    assign rx_bus.state_o     = r_state;
endmodule
